axis_dot_product: RTL and testbench

AXIS_DOT_PRODUCT -- requirements
Module: axis_dot_product

---
 rtl/matmul_pkg.sv | 17 +
 rtl/dot_mac.sv | 34 +++
 rtl/axis_dot_product.sv | 98 +++++++++
 tb/tb_axis_dot_product.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and constants for the dot-product datapath
package matmul_pkg;

    localparam int OP_W   = 16;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

endpackage

// File: rtl/dot_mac.sv
// rtl/dot_mac.sv - registered 16x16 signed multiply feeding a wrapping accumulator
module dot_mac
    import matmul_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear,
    input  logic signed [OP_W-1:0]  a,
    input  logic signed [OP_W-1:0]  b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [DATA_W-1:0] prod;
    logic                     prod_valid;

    // The product lands one cycle after the beat; the accumulate follows a cycle later.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            prod_valid <= enable;
            if (enable)
                prod <= DATA_W'(a) * DATA_W'(b);
            if (prod_valid)
                acc <= acc + {{(ACC_W-DATA_W){prod[DATA_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/axis_dot_product.sv
// rtl/axis_dot_product.sv - streaming signed dot product per frame; DOT_SATURATE_EN clamps results
module axis_dot_product
    import matmul_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       M_AXIS_Recive_tdata,
    input  logic [3:0]        M_AXIS_Recive_tkeep,
    input  logic              M_AXIS_Recive_tlast,
    input  logic              M_AXIS_Recive_tvalid,
    output logic              M_AXIS_Recive_tready,
    input  logic              axi_send_fifo_almost_full_0,
    output logic [31:0]       S_AXIS_Send_tdata,
    output logic [3:0]        S_AXIS_Send_tkeep,
    output logic              S_AXIS_Send_tlast,
    output logic              S_AXIS_Send_tvalid,
    input  logic              S_AXIS_Send_tready,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              ovf_sticky
);

    state_t                   state, state_next;
    logic                     beat, send_done;
    logic signed [OP_W-1:0]   a_in, b_in;
    logic signed [ACC_W-1:0]  acc;
    logic [ACC_W-DATA_W:0]    acc_hi;
    logic                     out_of_range;
    logic [DATA_W-1:0]        result;

    assign M_AXIS_Recive_tready = ((state == ST_IDLE) || (state == ST_ACC))
                                  && !axi_send_fifo_almost_full_0 && !reset;
    assign beat      = M_AXIS_Recive_tvalid && M_AXIS_Recive_tready;
    assign send_done = (state == ST_SEND) && S_AXIS_Send_tready;

    assign a_in = (M_AXIS_Recive_tkeep[1:0] == 2'b11) ? M_AXIS_Recive_tdata[15:0]  : '0;
    assign b_in = (M_AXIS_Recive_tkeep[3:2] == 2'b11) ? M_AXIS_Recive_tdata[31:16] : '0;

    dot_mac #(.ACC_W(ACC_W)) u_mac (
        .clock  (clock),
        .reset  (reset),
        .enable (beat),
        .clear  (send_done),
        .a      (a_in),
        .b      (b_in),
        .acc    (acc)
    );

    // In range only when every bit from bit 31 upward matches the sign.
    assign acc_hi       = acc[ACC_W-1:DATA_W-1];
    assign out_of_range = !((&acc_hi) || !(|acc_hi));

`ifdef DOT_SATURATE_EN
    assign result = out_of_range ? (acc[ACC_W-1] ? SAT_MIN : SAT_MAX) : acc[DATA_W-1:0];
`else
    assign result = acc[DATA_W-1:0];
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (beat) state_next = M_AXIS_Recive_tlast ? ST_FLUSH : ST_ACC;
            ST_ACC:   if (beat && M_AXIS_Recive_tlast) state_next = ST_FLUSH;
            ST_FLUSH: state_next = ST_SEND;
            ST_SEND:  if (S_AXIS_Send_tready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        S_AXIS_Send_tvalid = (state == ST_SEND);
        S_AXIS_Send_tdata  = S_AXIS_Send_tvalid ? result : '0;
        S_AXIS_Send_tkeep  = S_AXIS_Send_tvalid ? 4'hF : 4'h0;
        S_AXIS_Send_tlast  = S_AXIS_Send_tvalid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt  <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (send_done)
                frame_cnt <= frame_cnt + CNT_W'(1);
            if ((state == ST_SEND) && out_of_range)
                ovf_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_dot_product.sv
// tb/tb_axis_dot_product.sv - directed vector bench for axis_dot_product
module tb_axis_dot_product;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rx_tdata;
    logic [3:0]  rx_tkeep;
    logic        rx_tlast, rx_tvalid, rx_tready;
    logic        almost_full;
    logic [31:0] tx_tdata;
    logic [3:0]  tx_tkeep;
    logic        tx_tlast, tx_tvalid, tx_tready;
    logic [15:0] frame_cnt;
    logic        ovf_sticky;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic exp_ovf = 1'b0;

    always #5 clock = ~clock;

    axis_dot_product #(.ACC_W(48), .CNT_W(16)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .M_AXIS_Recive_tdata         (rx_tdata),
        .M_AXIS_Recive_tkeep         (rx_tkeep),
        .M_AXIS_Recive_tlast         (rx_tlast),
        .M_AXIS_Recive_tvalid        (rx_tvalid),
        .M_AXIS_Recive_tready        (rx_tready),
        .axi_send_fifo_almost_full_0 (almost_full),
        .S_AXIS_Send_tdata           (tx_tdata),
        .S_AXIS_Send_tkeep           (tx_tkeep),
        .S_AXIS_Send_tlast           (tx_tlast),
        .S_AXIS_Send_tvalid          (tx_tvalid),
        .S_AXIS_Send_tready          (tx_tready),
        .frame_cnt                   (frame_cnt),
        .ovf_sticky                  (ovf_sticky)
    );

    typedef struct {
        int                n;
        logic [3:0][31:0]  d;
        logic [3:0][3:0]   k;
        logic [31:0]       exp;
        logic              ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rx_ready();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (rx_tready) begin ok = 1; break; end
            @(negedge clock);
        end
        if (!ok) chk("rx_ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input int n, input logic [3:0][31:0] d, input logic [3:0][3:0] k);
        for (int i = 0; i < n; i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = d[i];
            rx_tkeep  = k[i];
            rx_tlast  = (i == n - 1);
            wait_rx_ready();
            @(negedge clock);
        end
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tdata = '0; rx_tkeep = '0;
    endtask

    // Called one negedge after the tlast beat was accepted; checks latency, result and handshake.
    task automatic collect(input string name, input logic [31:0] exp_data);
        chk({name, "_lat_n1"}, tx_tvalid, 0);
        @(negedge clock);
        chk({name, "_lat_n2"}, tx_tvalid, 1);
        chk({name, "_data"}, tx_tdata, exp_data);
        chk({name, "_keep_last"}, {tx_tkeep, tx_tlast}, {4'hF, 1'b1});
        tx_tready = 1'b1;
        @(negedge clock);
        tx_tready = 1'b0;
        exp_cnt++;
        chk({name, "_after_valid"}, tx_tvalid, 0);
        chk({name, "_after_data"}, tx_tdata, 0);
        chk({name, "_cnt"}, frame_cnt, exp_cnt);
    endtask

    initial begin
        logic [3:0][31:0] d;
        logic [3:0][3:0]  k;
        logic [31:0]      held;
        bit               stray;

        vecs[0] = '{3, {32'h0, 32'h0001_0007, 32'h0005_FFFE, 32'h0004_0003},
                    {4'h0, 4'hF, 4'hF, 4'hF}, 32'h0000_0009, 1'b0};
        vecs[1] = '{1, {32'h0, 32'h0, 32'h0, 32'h0002_0003},
                    {4'h0, 4'h0, 4'h0, 4'hF}, 32'h0000_0006, 1'b0};
        vecs[2] = '{2, {32'h0, 32'h0, 32'h0002_0002, 32'h0005_0005},
                    {4'h0, 4'h0, 4'hC, 4'h3}, 32'h0000_0000, 1'b0};
        vecs[3] = '{2, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0004_FFFD},
                    {4'h0, 4'h0, 4'hF, 4'hF}, 32'hFFFF_FFF5, 1'b0};
        vecs[4] = '{4, {32'h00C8_0064, 32'h00C8_0064, 32'h00C8_0064, 32'h00C8_0064},
                    {4'hF, 4'hF, 4'hF, 4'hF}, 32'h0001_3880, 1'b0};
`ifdef DOT_SATURATE_EN
        vecs[5] = '{3, {32'h0, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF},
                    {4'h0, 4'hF, 4'hF, 4'hF}, 32'h7FFF_FFFF, 1'b1};
        vecs[6] = '{3, {32'h0, 32'h7FFF_8000, 32'h7FFF_8000, 32'h7FFF_8000},
                    {4'h0, 4'hF, 4'hF, 4'hF}, 32'h8000_0000, 1'b1};
`else
        vecs[5] = '{3, {32'h0, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF},
                    {4'h0, 4'hF, 4'hF, 4'hF}, 32'hBFFD_0003, 1'b1};
        vecs[6] = '{3, {32'h0, 32'h7FFF_8000, 32'h7FFF_8000, 32'h7FFF_8000},
                    {4'h0, 4'hF, 4'hF, 4'hF}, 32'h4001_8000, 1'b1};
`endif

        reset = 1'b1; rx_tdata = '0; rx_tkeep = '0; rx_tlast = 1'b0; rx_tvalid = 1'b0;
        almost_full = 1'b0; tx_tready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_rx_ready", rx_tready, 0);
        chk("rst_tx", {tx_tvalid, tx_tlast, tx_tkeep, tx_tdata}, 0);
        chk("rst_cnt_ovf", {frame_cnt, ovf_sticky}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_rx_ready", rx_tready, 1);

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].n, vecs[v].d, vecs[v].k);
            collect($sformatf("vec%0d", v), vecs[v].exp);
            exp_ovf = exp_ovf | vecs[v].ovf;
            chk($sformatf("vec%0d_ovf", v), ovf_sticky, exp_ovf);
        end

        // Send-side backpressure: result must hold and the receive side must stay closed.
        d = '0; k = '0; d[0] = 32'h0002_0003; k[0] = 4'hF;
        send_frame(1, d, k);
        @(negedge clock);
        held = tx_tdata;
        chk("bp_first", held, 32'h0000_0006);
        rx_tvalid = 1'b1; rx_tdata = 32'h0001_0001; rx_tkeep = 4'hF; rx_tlast = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {tx_tvalid, rx_tready, tx_tdata}, {1'b1, 1'b0, held});
            @(negedge clock);
        end
        tx_tready = 1'b1; rx_tvalid = 1'b0; rx_tlast = 1'b0;
        @(negedge clock);
        tx_tready = 1'b0;
        exp_cnt++;
        chk("bp_cnt", frame_cnt, exp_cnt);
        @(negedge clock);
        chk("bp_single", tx_tvalid, 0);

        almost_full = 1'b1;
        #1;
        chk("af_rx_ready", rx_tready, 0);
        @(negedge clock);
        almost_full = 1'b0;
        #1;
        chk("af_release", rx_tready, 1);

        // Reset on the second beat of a four-beat frame.
        d = '0; k = '0; d[0] = 32'h0009_0009; k[0] = 4'hF;
        rx_tvalid = 1'b1; rx_tdata = d[0]; rx_tkeep = 4'hF; rx_tlast = 1'b0;
        wait_rx_ready();
        @(negedge clock);
        rx_tdata = 32'h0008_0008; reset = 1'b1;
        #1;
        chk("mid_rst_rx_ready", rx_tready, 0);
        repeat (2) @(negedge clock);
        chk("mid_rst_state", {tx_tvalid, frame_cnt, ovf_sticky}, 0);
        reset = 1'b0; rx_tvalid = 1'b0; rx_tdata = '0; rx_tkeep = '0;
        exp_cnt = 0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx_tvalid) stray = 1;
            @(negedge clock);
        end
        chk("mid_rst_no_beat", stray, 0);
        d = '0; k = '0; d[0] = 32'h0004_0003; k[0] = 4'hF;
        send_frame(1, d, k);
        collect("post_rst", 32'h0000_000C);
        chk("post_rst_ovf", ovf_sticky, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
